hazard_control_mc: RTL and testbench
====================================

// Module: hazard_control_mc
// PURPOSE
//  Pipeline hazard unit for the 5-stage RV32IM core, sitting beside the decode/execute/mem/writeback stages.
//  Generates operand forwarding selects for E, load-use stalls, branch flushes and multicycle stalls.
//  Multicycle ops are MUL class and DIV/REM class, each with a parametrised latency, tracked by a counter FSM.
// PARAMETERS
//  REG_AW      5  register address width (x0 = all-zero address, never forwarded/hazarded)
//  MUL_CYCLES  3  total E-stage occupancy of a MUL/MULH/MULHSU/MULHU op, >=1
//  DIV_CYCLES  8  total E-stage occupancy of a DIV/DIVU/REM/REMU op, >=1
//  CNT_W       4  counter width; must satisfy 2**CNT_W >= max(MUL_CYCLES,DIV_CYCLES)
// PORTS
//  clk              in   1       clock, all state on rising edge
//  reset            in   1       asynchronous, active-high reset
//  Dreg1_addr       in   REG_AW  rs1 of instruction in D
//  Dreg2_addr       in   REG_AW  rs2 of instruction in D
//  Ereg1_addr       in   REG_AW  rs1 of instruction in E
//  Ereg2_addr       in   REG_AW  rs2 of instruction in E
//  Ewrite_reg_addr  in   REG_AW  rd of instruction in E
//  Eload_sig        in   1       instruction in E is a load
//  Emul_req         in   1       instruction in E is MUL class
//  Ediv_req         in   1       instruction in E is DIV/REM class
//  Mwrite_reg_addr  in   REG_AW  rd in M;  Mwrite_reg_sig in 1  M writes rd
//  Wwrite_reg_addr  in   REG_AW  rd in W;  Wwrite_reg_sig in 1  W writes rd
//  branch_sig       in   1       taken branch/jump resolved in E
//  forward1E        out  2       rs1 select: 2'b00 NORMAL, 2'b01 WRITEBACK, 2'b10 WRITEMEM
//  forward2E        out  2       rs2 select, same encoding
//  stallF/stallD    out  1       hold PC / hold F->D register
//  stallE           out  1       hold D->E register
//  flushD/flushE    out  1       bubble into D->E / E->M register respectively (flushE: bubble into M)
//  md_busy          out  1       FSM in BUSY state
// BEHAVIOUR
//  Forwarding (combinational, per operand): addr!=0 && Mwrite_reg_sig && addr==Mwrite_reg_addr -> 2'b10;
//   else addr!=0 && Wwrite_reg_sig && addr==Wwrite_reg_addr -> 2'b01; else 2'b00. M beats W.
//  FSM states IDLE, BUSY; counter cnt[CNT_W-1:0]. Reset -> IDLE, cnt=0, immediately (async).
//  N = MUL_CYCLES if Emul_req else DIV_CYCLES if Ediv_req. Both high: MUL wins.
//  IDLE & req & N>1: mc_stall=1; next BUSY, cnt<=N-2. IDLE & req & N==1: no stall, stay IDLE.
//  BUSY: mc_stall = (cnt!=0); cnt!=0 -> cnt<=cnt-1; cnt==0 -> next IDLE (op leaves E this cycle).
//  req while BUSY is the same instruction: ignored, never retriggers. Stall cycles per op = N-1 exactly.
//  mc_stall: stallF=stallD=stallE=1, flushE=1 (bubble to M), flushD=0; branch_sig ignored.
//  Load-use (no mc_stall): Eload_sig && Ewrite_reg_addr!=0 && (==Dreg1_addr || ==Dreg2_addr)
//   -> stallF=stallD=1, flushD=1 (bubble into E), stallE=0, flushE=0. One cycle per occurrence.
//  Branch (no mc_stall): branch_sig -> flushD=1, flushE=0, stallF=stallD=0; overrides load-use.
//  Priority: reset > mc_stall > branch > load-use > none (all stall/flush 0).
//  While reset high: all stall/flush outputs 0, md_busy 0; forward outputs stay combinational.
//  Reset mid-operation: BUSY aborted, cnt=0; after release, a still-present req starts a new count.
//  md_busy = (state==BUSY), registered state only.
// TESTING
//  Ereg1=5, Mwrite=5/sig1, Wwrite=5/sig1 -> forward1E=2'b10; Msig=0 -> 2'b01; Ereg1=0 -> 2'b00.
//  MUL_CYCLES=3, Emul_req held 3 cycles -> stallF/D/E=1 for exactly cycles 0,1; cycle 2 stalls 0, md_busy 1 in cycle 1-2.
//  DIV_CYCLES=8, Ediv_req -> 7 stall cycles, flushE=1 each; next cycle IDLE, no retrigger with req still high that edge.
//  Eload_sig=1, Ewrite=7, Dreg2=7 -> stallF=stallD=flushD=1 one cycle; Ewrite=0 -> no stall.
//  Load-use and branch_sig same cycle -> flushD=1, stallF=stallD=0.
//  reset pulsed in DIV BUSY (cnt=4) -> stalls drop at once, md_busy=0; MUL/DIV with N=1 -> never stalls.

Source files
------------

// File: rtl/hazard_control_mc.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_control_mc
//  Description : Hazard unit for a 5-stage RV32IM pipeline.
//                Its jobs are:
//                  - select the operand forwarding source for the E stage;
//                  - stall on load-use hazards;
//                  - flush when a branch is taken;
//                  - stall while a MUL or DIV/REM op occupies E. A small
//                    IDLE/BUSY counter FSM tracks these ops.
//  Ports       : clk, reset (async, active-high)
//                Dreg1_addr/Dreg2_addr         - rs1/rs2 of the op in D
//                Ereg1_addr/Ereg2_addr         - rs1/rs2 of the op in E
//                Ewrite_reg_addr, Eload_sig    - rd of E, E is a load
//                Emul_req/Ediv_req             - E holds a MUL / DIV-class op
//                Mwrite_reg_addr/_sig          - rd and write enable in M
//                Wwrite_reg_addr/_sig          - rd and write enable in W
//                branch_sig                    - taken branch/jump in E
//                forward1E/forward2E           - 00 reg file, 01 W, 10 M
//                stallF/stallD/stallE          - hold PC, F->D reg, D->E reg
//                flushD/flushE                 - bubble into E / into M
//                md_busy                       - multicycle FSM is BUSY
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_control_mc #(
  parameter int REG_AW     = 5,
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 8,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Dreg1_addr,
  input  logic [REG_AW-1:0] Dreg2_addr,
  input  logic [REG_AW-1:0] Ereg1_addr,
  input  logic [REG_AW-1:0] Ereg2_addr,
  input  logic [REG_AW-1:0] Ewrite_reg_addr,
  input  logic              Eload_sig,
  input  logic              Emul_req,
  input  logic              Ediv_req,
  input  logic [REG_AW-1:0] Mwrite_reg_addr,
  input  logic              Mwrite_reg_sig,
  input  logic [REG_AW-1:0] Wwrite_reg_addr,
  input  logic              Wwrite_reg_sig,
  input  logic              branch_sig,
  output logic [1:0]        forward1E,
  output logic [1:0]        forward2E,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              flushD,
  output logic              flushE,
  output logic              md_busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // The first occupancy cycle is spent in IDLE, so BUSY counts down from N-2.
  // Single-cycle ops never enter BUSY; their load value is unused.
  localparam logic             MUL_MULTI = (MUL_CYCLES > 1);
  localparam logic             DIV_MULTI = (DIV_CYCLES > 1);
  localparam logic [CNT_W-1:0] MUL_LOAD  = (MUL_CYCLES > 1) ? CNT_W'(MUL_CYCLES - 2) : '0;
  localparam logic [CNT_W-1:0] DIV_LOAD  = (DIV_CYCLES > 1) ? CNT_W'(DIV_CYCLES - 2) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mc_stall;
  logic             mc_req;
  logic             mc_multi;
  logic [CNT_W-1:0] mc_load;
  logic             load_use;

  // Forwarding. x0 is never forwarded. When M and W both match, M wins
  // because M holds the younger result.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] addr,
    input logic [REG_AW-1:0] m_addr,
    input logic              m_we,
    input logic [REG_AW-1:0] w_addr,
    input logic              w_we
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (addr != '0 && m_we && addr == m_addr) begin
      sel = 2'b10;
    end else if (addr != '0 && w_we && addr == w_addr) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign forward1E = fwd_sel(Ereg1_addr, Mwrite_reg_addr, Mwrite_reg_sig,
                             Wwrite_reg_addr, Wwrite_reg_sig);
  assign forward2E = fwd_sel(Ereg2_addr, Mwrite_reg_addr, Mwrite_reg_sig,
                             Wwrite_reg_addr, Wwrite_reg_sig);

  // A MUL request takes precedence over a DIV request when both are set.
  assign mc_req   = Emul_req | Ediv_req;
  assign mc_multi = Emul_req ? MUL_MULTI : DIV_MULTI;
  assign mc_load  = Emul_req ? MUL_LOAD  : DIV_LOAD;

  assign load_use = Eload_sig && (Ewrite_reg_addr != '0) &&
                    ((Ewrite_reg_addr == Dreg1_addr) || (Ewrite_reg_addr == Dreg2_addr));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // While BUSY, a request is the same op still sitting in E, so it is
  // ignored. The cnt==0 cycle is the op's last cycle in E and does not stall.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (mc_req && mc_multi) begin
          mc_stall = 1'b1;
          state_d  = BUSY;
          cnt_d    = mc_load;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          mc_stall = 1'b1;
          cnt_d    = cnt_q - CNT_ONE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Stall and flush outputs. The priority order, highest first, is:
  // reset, multicycle stall, branch, load-use.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    if (reset) begin
      // Hold everything quiet. The FSM registers are already cleared.
    end else if (mc_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushE = 1'b1;
    end else if (branch_sig) begin
      flushD = 1'b1;
    end else if (load_use) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushD = 1'b1;
    end
  end

  assign md_busy = (state_q == BUSY);

endmodule
`default_nettype wire

// File: tb/tb_hazard_control_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_control_mc
//  Description : Self-checking bench for hazard_control_mc. Vectors are
//                applied one per clock cycle. Expected values are queued when
//                the inputs are driven and compared at the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_control_mc;

  typedef struct packed {
    logic       rst;
    logic [4:0] d1, d2, e1, e2, ew;
    logic       eload, emul, ediv;
    logic [4:0] mw;
    logic       msig;
    logic [4:0] ww;
    logic       wsig;
    logic       br;
    logic [9:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] Dreg1_addr = '0, Dreg2_addr = '0, Ereg1_addr = '0, Ereg2_addr = '0;
  logic [4:0] Ewrite_reg_addr = '0, Mwrite_reg_addr = '0, Wwrite_reg_addr = '0;
  logic       Eload_sig = 1'b0, Emul_req = 1'b0, Ediv_req = 1'b0;
  logic       Mwrite_reg_sig = 1'b0, Wwrite_reg_sig = 1'b0, branch_sig = 1'b0;

  logic [1:0] f1_a, f2_a, f1_b, f2_b;
  logic       sF_a, sD_a, sE_a, fD_a, fE_a, bz_a;
  logic       sF_b, sD_b, sE_b, fD_b, fE_b, bz_b;
  logic [9:0] act_a, act_b;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [9:0] exp_q[$];
  vec_t       tbl[$];

  always #5 clk = ~clk;

  hazard_control_mc #(.REG_AW(5), .MUL_CYCLES(3), .DIV_CYCLES(8), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset),
    .Dreg1_addr(Dreg1_addr), .Dreg2_addr(Dreg2_addr),
    .Ereg1_addr(Ereg1_addr), .Ereg2_addr(Ereg2_addr),
    .Ewrite_reg_addr(Ewrite_reg_addr), .Eload_sig(Eload_sig),
    .Emul_req(Emul_req), .Ediv_req(Ediv_req),
    .Mwrite_reg_addr(Mwrite_reg_addr), .Mwrite_reg_sig(Mwrite_reg_sig),
    .Wwrite_reg_addr(Wwrite_reg_addr), .Wwrite_reg_sig(Wwrite_reg_sig),
    .branch_sig(branch_sig),
    .forward1E(f1_a), .forward2E(f2_a),
    .stallF(sF_a), .stallD(sD_a), .stallE(sE_a),
    .flushD(fD_a), .flushE(fE_a), .md_busy(bz_a)
  );

  // Single-cycle multiply/divide variant: must never stall.
  hazard_control_mc #(.REG_AW(5), .MUL_CYCLES(1), .DIV_CYCLES(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset(reset),
    .Dreg1_addr(Dreg1_addr), .Dreg2_addr(Dreg2_addr),
    .Ereg1_addr(Ereg1_addr), .Ereg2_addr(Ereg2_addr),
    .Ewrite_reg_addr(Ewrite_reg_addr), .Eload_sig(Eload_sig),
    .Emul_req(Emul_req), .Ediv_req(Ediv_req),
    .Mwrite_reg_addr(Mwrite_reg_addr), .Mwrite_reg_sig(Mwrite_reg_sig),
    .Wwrite_reg_addr(Wwrite_reg_addr), .Wwrite_reg_sig(Wwrite_reg_sig),
    .branch_sig(branch_sig),
    .forward1E(f1_b), .forward2E(f2_b),
    .stallF(sF_b), .stallD(sD_b), .stallE(sE_b),
    .flushD(fD_b), .flushE(fE_b), .md_busy(bz_b)
  );

  assign act_a = {f1_a, f2_a, sF_a, sD_a, sE_a, fD_a, fE_a, bz_a};
  assign act_b = {f1_b, f2_b, sF_b, sD_b, sE_b, fD_b, fE_b, bz_b};

  // Packs the expected outputs as {fwd1, fwd2, stallF, stallD, stallE,
  // flushD, flushE, md_busy}.
  function automatic logic [9:0] ex(input logic [1:0] f1, input logic [1:0] f2,
                                    input logic sF, input logic sD, input logic sE,
                                    input logic fD, input logic fE, input logic bz);
    return {f1, f2, sF, sD, sE, fD, fE, bz};
  endfunction

  function automatic vec_t mk(input logic rst, input logic [4:0] d1, input logic [4:0] d2,
                              input logic [4:0] e1, input logic [4:0] e2, input logic [4:0] ew,
                              input logic eload, input logic emul, input logic ediv,
                              input logic [4:0] mw, input logic msig,
                              input logic [4:0] ww, input logic wsig,
                              input logic br, input logic [9:0] exp);
    vec_t v;
    v.rst = rst; v.d1 = d1; v.d2 = d2; v.e1 = e1; v.e2 = e2; v.ew = ew;
    v.eload = eload; v.emul = emul; v.ediv = ediv;
    v.mw = mw; v.msig = msig; v.ww = ww; v.wsig = wsig; v.br = br; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset           = v.rst;
    Dreg1_addr      = v.d1;
    Dreg2_addr      = v.d2;
    Ereg1_addr      = v.e1;
    Ereg2_addr      = v.e2;
    Ewrite_reg_addr = v.ew;
    Eload_sig       = v.eload;
    Emul_req        = v.emul;
    Ediv_req        = v.ediv;
    Mwrite_reg_addr = v.mw;
    Mwrite_reg_sig  = v.msig;
    Wwrite_reg_addr = v.ww;
    Wwrite_reg_sig  = v.wsig;
    branch_sig      = v.br;
    exp_q.push_back(v.exp);
  endtask

  task automatic check(input string nm, input logic [9:0] act);
    logic [9:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, actual %b", nm, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: actual %b required %b (f1,f2,sF,sD,sE,fD,fE,busy)", nm, act, e);
      end
    end
  endtask

  // Drives one vector after a rising edge and checks it at the next falling edge.
  task automatic step(input vec_t v, input string nm, input bit use_b);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    check(nm, use_b ? act_b : act_a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- table ----------------
    // Reset: forwarding stays live, stalls are masked even with a request.
    tbl.push_back(mk(1, 0,0, 5,0, 0, 0,1,0, 5,1, 0,0, 0, ex(2'b10,2'b00,0,0,0,0,0,0)));
    // Forwarding.
    tbl.push_back(mk(0, 0,0, 5,0, 0, 0,0,0, 5,1, 5,1, 0, ex(2'b10,2'b00,0,0,0,0,0,0)));
    tbl.push_back(mk(0, 0,0, 5,0, 0, 0,0,0, 5,0, 5,1, 0, ex(2'b01,2'b00,0,0,0,0,0,0)));
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0,0,0, 0,1, 0,1, 0, ex(2'b00,2'b00,0,0,0,0,0,0)));
    tbl.push_back(mk(0, 0,0, 3,9, 0, 0,0,0, 3,1, 9,1, 0, ex(2'b10,2'b01,0,0,0,0,0,0)));
    tbl.push_back(mk(0, 0,0, 3,9, 0, 0,0,0, 9,0, 3,0, 0, ex(2'b00,2'b00,0,0,0,0,0,0)));
    // Load-use hazards.
    tbl.push_back(mk(0, 0,7, 0,0, 7, 1,0,0, 0,0, 0,0, 0, ex(2'b00,2'b00,1,1,0,1,0,0)));
    tbl.push_back(mk(0, 0,0, 0,0, 0, 1,0,0, 0,0, 0,0, 0, ex(2'b00,2'b00,0,0,0,0,0,0)));
    tbl.push_back(mk(0, 7,0, 0,0, 7, 1,0,0, 0,0, 0,0, 1, ex(2'b00,2'b00,0,0,0,1,0,0)));
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0,0,0, 0,0, 0,0, 1, ex(2'b00,2'b00,0,0,0,1,0,0)));
    // MUL, N=3. The first cycle also carries a branch and a load-use,
    // both of which lose to the multicycle stall.
    tbl.push_back(mk(0, 7,0, 0,0, 7, 1,1,0, 0,0, 0,0, 1, ex(2'b00,2'b00,1,1,1,0,1,0)));
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0,1,0, 0,0, 0,0, 0, ex(2'b00,2'b00,1,1,1,0,1,1)));
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0,1,0, 0,0, 0,0, 0, ex(2'b00,2'b00,0,0,0,0,0,1)));
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0,0,0, 0,0, 0,0, 0, ex(2'b00,2'b00,0,0,0,0,0,0)));
    // DIV, N=8: 7 stall cycles, one BUSY exit cycle, then idle.
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0,0,1, 0,0, 0,0, 0, ex(2'b00,2'b00,1,1,1,0,1,0)));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(0, 0,0, 0,0, 0, 0,0,1, 0,0, 0,0, 0, ex(2'b00,2'b00,1,1,1,0,1,1)));
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0,0,1, 0,0, 0,0, 0, ex(2'b00,2'b00,0,0,0,0,0,1)));
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0,0,0, 0,0, 0,0, 0, ex(2'b00,2'b00,0,0,0,0,0,0)));
    // MUL and DIV both requested: MUL wins, so the op lasts 3 cycles.
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0,1,1, 0,0, 0,0, 0, ex(2'b00,2'b00,1,1,1,0,1,0)));
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0,1,1, 0,0, 0,0, 0, ex(2'b00,2'b00,1,1,1,0,1,1)));
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0,1,1, 0,0, 0,0, 0, ex(2'b00,2'b00,0,0,0,0,0,1)));
    tbl.push_back(mk(0, 0,0, 0,0, 0, 0,0,0, 0,0, 0,0, 0, ex(2'b00,2'b00,0,0,0,0,0,0)));

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i), 1'b0);

    // ---------------- reset in the middle of a DIV ----------------
    step(mk(0,0,0,0,0,0,0,0,1,0,0,0,0,0, ex(2'b00,2'b00,1,1,1,0,1,0)), "div_rst_c0", 1'b0);
    step(mk(0,0,0,0,0,0,0,0,1,0,0,0,0,0, ex(2'b00,2'b00,1,1,1,0,1,1)), "div_rst_c1", 1'b0);
    step(mk(0,0,0,0,0,0,0,0,1,0,0,0,0,0, ex(2'b00,2'b00,1,1,1,0,1,1)), "div_rst_c2", 1'b0);
    step(mk(0,0,0,0,0,0,0,0,1,0,0,0,0,0, ex(2'b00,2'b00,1,1,1,0,1,1)), "div_rst_cnt4", 1'b0);
    #1;
    drive(mk(1,0,0,0,0,0,0,0,1,0,0,0,0,0, ex(2'b00,2'b00,0,0,0,0,0,0)));
    #1;
    check("div_rst_async", act_a);
    // After reset is released, the request that is still present starts a new count.
    step(mk(0,0,0,0,0,0,0,0,1,0,0,0,0,0, ex(2'b00,2'b00,1,1,1,0,1,0)), "div_restart_c0", 1'b0);
    step(mk(0,0,0,0,0,0,0,0,1,0,0,0,0,0, ex(2'b00,2'b00,1,1,1,0,1,1)), "div_restart_c1", 1'b0);
    step(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0, ex(2'b00,2'b00,0,0,0,0,0,0)), "cleanup_rst", 1'b0);

    // ---------------- N=1 variant ----------------
    step(mk(0,0,0,0,0,0,0,1,0,0,0,0,0,0, ex(2'b00,2'b00,0,0,0,0,0,0)), "n1_mul_c0", 1'b1);
    step(mk(0,0,0,0,0,0,0,1,0,0,0,0,0,0, ex(2'b00,2'b00,0,0,0,0,0,0)), "n1_mul_c1", 1'b1);
    step(mk(0,0,0,0,0,0,0,0,1,0,0,0,0,0, ex(2'b00,2'b00,0,0,0,0,0,0)), "n1_div_c0", 1'b1);
    step(mk(0,0,0,0,0,0,0,0,1,0,0,0,0,0, ex(2'b00,2'b00,0,0,0,0,0,0)), "n1_div_c1", 1'b1);
    step(mk(0,0,7,0,0,7,1,0,0,0,0,0,0,0, ex(2'b00,2'b00,1,1,0,1,0,0)), "n1_loaduse", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
